// File: rtl/fetch_npc_unit_if.sv
// Fetch next-PC interface: D-stage/CP0 redirect controls in, F-stage
// fetch address and flags out. master = control side, slave = fetch unit.
interface fetch_npc_unit_if;
    logic        Stall;
    logic [31:0] D_PC;
    logic        D_CtrlXfer;
    logic        BrWE;
    logic        Jump;
    logic        JumpReg;
    logic [15:0] Imm16;
    logic [25:0] Index26;
    logic [31:0] RD1;
    logic        Req;
    logic        Eret;
    logic [31:0] EPC;
    logic [31:0] F_PC;
    logic        F_BD;
    logic        F_ExcAdEL;
    logic        F_Valid;

    modport master (
        output Stall, D_PC, D_CtrlXfer, BrWE, Jump, JumpReg,
        output Imm16, Index26, RD1, Req, Eret, EPC,
        input  F_PC, F_BD, F_ExcAdEL, F_Valid
    );

    modport slave (
        input  Stall, D_PC, D_CtrlXfer, BrWE, Jump, JumpReg,
        input  Imm16, Index26, RD1, Req, Eret, EPC,
        output F_PC, F_BD, F_ExcAdEL, F_Valid
    );
endinterface

// File: rtl/fetch_npc_unit.sv
// F-stage PC register and next-PC selector (BOOT/RUN FSM).
// Ports: clk, reset (async active-low), bus (fetch_npc_unit_if.slave).
// Optional macro FETCH_RANGE_CHECK_EN adds fetch address range checking.
module fetch_npc_unit #(
    parameter logic [31:0] PC_RESET  = 32'h0000_3000,
    parameter logic [31:0] EXC_ENTRY = 32'h0000_4180
) (
    input  logic             clk,
    input  logic             reset,
    fetch_npc_unit_if.slave  bus
);
    typedef enum logic {BOOT = 1'b0, RUN = 1'b1} state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic        r_valid;

    logic [31:0] w_pc_plus4;
    logic [31:0] w_dpc_plus4;
    logic [31:0] w_br_off;
    logic [31:0] w_br_tgt;
    logic [31:0] w_j_tgt;
    logic [31:0] w_npc;
    logic        w_misalign;
    logic        w_range_err;

    assign w_pc_plus4  = r_pc + 32'd4;
    assign w_dpc_plus4 = bus.D_PC + 32'd4;
    assign w_br_off    = {{14{bus.Imm16[15]}}, bus.Imm16, 2'b00};
    assign w_br_tgt    = w_dpc_plus4 + w_br_off;
    assign w_j_tgt     = {w_dpc_plus4[31:28], bus.Index26, 2'b00};

    // Exception and eret must win over a stall, so they sit above it.
    always_comb begin
        w_npc = w_pc_plus4;
        priority case (1'b1)
            bus.Req:     w_npc = EXC_ENTRY;
            bus.Eret:    w_npc = bus.EPC;
            bus.Stall:   w_npc = r_pc;
            bus.JumpReg: w_npc = bus.RD1;
            bus.Jump:    w_npc = w_j_tgt;
            bus.BrWE:    w_npc = w_br_tgt;
            default:     w_npc = w_pc_plus4;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= BOOT;
            r_pc    <= PC_RESET;
            r_valid <= 1'b0;
        end else begin
            unique case (r_state)
                BOOT: begin
                    r_state <= RUN;
                    r_valid <= 1'b1;
                end
                RUN: begin
                    r_pc <= w_npc;
                end
                default: begin
                    r_state <= BOOT;
                end
            endcase
        end
    end

    assign w_misalign = (r_pc[1:0] != 2'b00);

`ifdef FETCH_RANGE_CHECK_EN
    assign w_range_err = (r_pc < 32'h0000_3000) || (r_pc > 32'h0000_6FFC);
`else
    assign w_range_err = 1'b0;
`endif

    assign bus.F_PC      = r_pc;
    assign bus.F_Valid   = r_valid;
    assign bus.F_BD      = bus.D_CtrlXfer & ~bus.Stall & r_valid;
    assign bus.F_ExcAdEL = r_valid & (w_misalign | w_range_err);
endmodule

// File: tb/tb_fetch_npc_unit.sv
// Directed testbench for fetch_npc_unit.
// Drives redirect vectors and checks F_PC and flags against hand values.
module tb_fetch_npc_unit;
    logic clk;
    logic rst_n;
    int   n_tot;
    int   n_pass;

    fetch_npc_unit_if bus ();

    fetch_npc_unit dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tot++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", tag, obs, exp);
    endtask

    task automatic clr();
        bus.Stall      = 1'b0;
        bus.D_PC       = 32'h0;
        bus.D_CtrlXfer = 1'b0;
        bus.BrWE       = 1'b0;
        bus.Jump       = 1'b0;
        bus.JumpReg    = 1'b0;
        bus.Imm16      = 16'h0;
        bus.Index26    = 26'h0;
        bus.RD1        = 32'h0;
        bus.Req        = 1'b0;
        bus.Eret       = 1'b0;
        bus.EPC        = 32'h0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic exp_range;

    initial begin
        n_tot  = 0;
        n_pass = 0;
`ifdef FETCH_RANGE_CHECK_EN
        exp_range = 1'b1;
`else
        exp_range = 1'b0;
`endif
        clr();
        rst_n = 1'b0;
        step();
        step();
        chk("rst_pc",    bus.F_PC,      32'h3000);
        chk("rst_valid", 32'(bus.F_Valid),   0);
        chk("rst_bd",    32'(bus.F_BD),      0);
        chk("rst_adel",  32'(bus.F_ExcAdEL), 0);

        rst_n = 1'b1;
        #1;
        chk("boot_pc",    bus.F_PC,          32'h3000);
        chk("boot_valid", 32'(bus.F_Valid),  0);
        step();
        chk("run_pc0",    bus.F_PC,          32'h3000);
        chk("run_valid",  32'(bus.F_Valid),  1);
        step();
        chk("seq_3004",   bus.F_PC,          32'h3004);
        step();
        chk("seq_3008",   bus.F_PC,          32'h3008);

        // backward branch
        bus.D_PC = 32'h3010; bus.BrWE = 1'b1;
        bus.Imm16 = 16'hFFFC; bus.D_CtrlXfer = 1'b1;
        #1;
        chk("br_bd", 32'(bus.F_BD), 1);
        step();
        chk("br_pc", bus.F_PC, 32'h3004);

        // stall discards the redirect
        bus.Stall = 1'b1; bus.Jump = 1'b1;
        #1;
        chk("stall_bd", 32'(bus.F_BD), 0);
        step();
        chk("stall_pc1", bus.F_PC, 32'h3004);
        step();
        chk("stall_pc2", bus.F_PC, 32'h3004);
        bus.Stall = 1'b0; bus.BrWE = 1'b0;
        bus.Index26 = 26'h0000C40; bus.D_PC = 32'h3020;
        step();
        chk("jump_pc", bus.F_PC, 32'h3100);
        clr();

        // Req beats stall and jr
        bus.Req = 1'b1; bus.Stall = 1'b1;
        bus.JumpReg = 1'b1; bus.RD1 = 32'h3200;
        step();
        chk("req_pc", bus.F_PC, 32'h4180);
        clr();
        bus.Eret = 1'b1; bus.EPC = 32'h3204; bus.Stall = 1'b1;
        step();
        chk("eret_pc", bus.F_PC, 32'h3204);
        clr();
        step();
        chk("eret_seq", bus.F_PC, 32'h3208);

        // jr wins over j and branch
        bus.JumpReg = 1'b1; bus.RD1 = 32'h3300;
        bus.Jump = 1'b1; bus.BrWE = 1'b1;
        bus.D_PC = 32'h3000; bus.Index26 = 26'h0000D00;
        step();
        chk("prio_jr", bus.F_PC, 32'h3300);
        bus.JumpReg = 1'b0;
        bus.Imm16 = 16'h0010;
        step();
        chk("prio_j", bus.F_PC, 32'h3400);
        bus.Jump = 1'b0; bus.D_PC = 32'h3400;
        step();
        chk("br_fwd", bus.F_PC, 32'h3444);
        clr();

        // misaligned fetch
        bus.JumpReg = 1'b1; bus.RD1 = 32'h3002;
        step();
        chk("mis_pc",   bus.F_PC, 32'h3002);
        chk("mis_adel", 32'(bus.F_ExcAdEL), 1);
        clr();
        step();
        chk("mis_seq",  bus.F_PC, 32'h3006);
        chk("mis_adel2", 32'(bus.F_ExcAdEL), 1);

        // range edges
        bus.JumpReg = 1'b1; bus.RD1 = 32'h7000;
        step();
        chk("rng_hi", 32'(bus.F_ExcAdEL), 32'(exp_range));
        bus.RD1 = 32'h6FFC;
        step();
        chk("rng_top", 32'(bus.F_ExcAdEL), 0);
        bus.RD1 = 32'h2FFC;
        step();
        chk("rng_lo", 32'(bus.F_ExcAdEL), 32'(exp_range));

        // wrap around
        bus.RD1 = 32'hFFFF_FFFC;
        step();
        chk("wrap_top", bus.F_PC, 32'hFFFF_FFFC);
        clr();
        step();
        chk("wrap_0", bus.F_PC, 32'h0);

        // async reset mid-run
        bus.JumpReg = 1'b1; bus.RD1 = 32'h3abc;
        step();
        clr();
        chk("pre_rst", bus.F_PC, 32'h3abc);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_pc",    bus.F_PC,         32'h3000);
        chk("arst_valid", 32'(bus.F_Valid), 0);
        step();
        rst_n = 1'b1;
        #1;
        chk("arst_boot", 32'(bus.F_Valid), 0);
        step();
        chk("arst_run",  32'(bus.F_Valid), 1);
        chk("arst_pc2",  bus.F_PC,         32'h3000);
        step();
        chk("arst_seq",  bus.F_PC,         32'h3004);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule

// File: doc/fetch_npc_unit.md
Name: fetch_npc_unit

Overview:
- F-stage program-counter register and next-PC selector for the 5-stage MIPS pipeline.
- Consumes the D-stage branch decision (BrWE) and the jump/eret/exception controls, and produces F_PC for the instruction memory.
- Also produces the F-stage delay-slot flag and the fetch address-error flag, which travel with the instruction into the F/D register.

Parameters:
- PC_RESET, 32'h0000_3000, PC value loaded by reset.
- EXC_ENTRY, 32'h0000_4180, exception handler entry address.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- Stall  in  1  hazard stall; holds the PC and the D-stage redirect.
- D_PC  in  32  PC of the instruction in D.
- D_CtrlXfer  in  1  D holds a branch, j, jal, jr or jalr.
- BrWE  in  1  branch taken, from the D-stage comparator.
- Jump  in  1  D holds j/jal.
- JumpReg  in  1  D holds jr/jalr.
- Imm16  in  16  D instruction [15:0].
- Index26  in  26  D instruction [25:0].
- RD1  in  32  forwarded rs value (jr target).
- Req  in  1  exception/interrupt request from CP0.
- Eret  in  1  eret in D.
- EPC  in  32  CP0 EPC value.
- F_PC  out  32  current fetch address.
- F_BD  out  1  instruction in F is a delay slot.
- F_ExcAdEL  out  1  fetch address error for F_PC.
- F_Valid  out  1  F_PC is a real fetch (0 in the boot cycle).

Behaviour:
- Reset (reset=0, asynchronous):
  - PC register = PC_RESET.
  - state = BOOT.
  - F_Valid=0, F_BD=0, F_ExcAdEL=0.
- FSM with two states.
  - BOOT: lasts exactly one clk after reset deasserts. PC is held and F_Valid=0. Then go to RUN unconditionally; Stall is ignored in BOOT.
  - RUN: F_Valid=1, and stays 1 until the next reset.
- Next PC in RUN, in strict priority order, registered on the rising edge:
  1. Req=1 -> EXC_ENTRY. Overrides Stall and all other sources.
  2. Eret=1 -> EPC. Overrides Stall; no delay slot.
  3. Stall=1 -> hold PC. Any D-stage redirect this cycle is discarded; D re-presents it after the stall.
  4. JumpReg=1 -> RD1.
  5. Jump=1 -> {D_PC_plus4[31:28], Index26, 2'b00}, where D_PC_plus4 = D_PC+4.
  6. BrWE=1 -> D_PC + 4 + (sign-extend(Imm16) << 2).
  7. Otherwise -> F_PC + 4.
- Arithmetic and flags:
  - All adds are 32-bit modulo; F_PC+4 at 32'hFFFF_FFFC wraps to 0.
  - Jump, JumpReg and BrWE set together is a decoder error; the priority above still applies.
  - F_BD = D_CtrlXfer & ~Stall & F_Valid, combinational from the current inputs.
  - F_ExcAdEL = F_Valid & (F_PC[1:0] != 0), combinational.
- Latency: a redirect presented in cycle n appears on F_PC in cycle n+1.
- Reset mid-operation takes effect immediately, regardless of Req/Eret/Stall.

Optional Feature:
- Macro FETCH_RANGE_CHECK_EN.
- Defined: F_ExcAdEL also asserts when F_PC < 32'h0000_3000 or F_PC > 32'h0000_6FFC (with F_Valid=1).
- Undefined: only the misalignment check applies; the out-of-range comparators are not built.

Test Plan:
- Reset release -> F_PC=0x3000 for 2 cycles (F_Valid 0 then 1), then 0x3004, 0x3008 on consecutive cycles.
- D_PC=0x3010, BrWE=1, Imm16=16'hFFFC, Stall=0 -> next F_PC=0x3004, and F_BD=1 during that cycle.
- Stall=1 with BrWE=1, Jump=1 -> F_PC held for the whole stall, F_BD=0. Stall drops with Jump=1, Index26=26'h0000C40, D_PC=0x3020 -> F_PC=0x3100.
- Req=1 together with Stall=1 and JumpReg=1 (RD1=0x3200) -> F_PC=0x4180 next cycle. Eret=1, EPC=0x3204 -> F_PC=0x3204 next cycle, no extra sequential instruction.
- JumpReg=1, RD1=0x3002 -> F_PC=0x3002, F_ExcAdEL=1. With FETCH_RANGE_CHECK_EN, RD1=0x7000 -> F_ExcAdEL=1; without it -> F_ExcAdEL=0.
- reset asserted mid-run at F_PC=0x3abc -> F_PC=0x3000 immediately (asynchronous), F_Valid=0 until one cycle after release.
